pingpong_frame_ctrl: RTL and testbench

//  Sequences two 512x16 SDPB sample RAMs (ram0_512 / ram1_512 instances) as a ping-pong frame buffer.

---
 rtl/acam_pkg.sv | 24 ++
 rtl/pp_rd_seq.sv | 150 +++++++++++++++
 rtl/pingpong_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_pingpong_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acam_pkg.sv
// Shared definitions for the acoustic capture path.
// Holds the sample/frame geometry, the read-sequencer state encoding and a
// small bank-select helper used by both the frame controller and its reader.
package acam_pkg;

   localparam int SAMPLE_W = 16;
   localparam int FRAME_AW = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // One-hot bank enable for a 1-bit bank index (bank0 = bit0).
   function automatic logic [1:0] bank_sel(input logic bank);
      if (bank) begin
         return 2'b10;
      end else begin
         return 2'b01;
      end
   endfunction

endpackage

// File: rtl/pp_rd_seq.sv
// Read sequencer of the ping-pong frame buffer.
// Streams one full bank as a burst of 2**AW addresses, then waits RD_LAT
// cycles for the last RAM data before releasing the bank.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rd_start, frame_rdy   consumer request / a readable bank exists
//   next_bank             oldest full bank, latched at burst start
//   ram_ceb, ram_adb      RAM B port read enable (one-hot) and address
//   busy, rd_bank         a burst owns rd_bank
//   rd_done               one-cycle pulse: burst finished, free rd_bank
//   out_valid, out_last   read issue delayed by RD_LAT
//   out_bank              bank of the data currently on the RAM outputs
module pp_rd_seq
   import acam_pkg::*;
#(
   parameter int AW     = FRAME_AW,
   parameter int RD_LAT = 1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_start,
   input  logic          frame_rdy,
   input  logic          next_bank,
   output logic [1:0]    ram_ceb,
   output logic [AW-1:0] ram_adb,
   output logic          busy,
   output logic          rd_bank,
   output logic          rd_done,
   output logic          out_valid,
   output logic          out_last,
   output logic          out_bank
);

   localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [AW-1:0]  PTR_LAST   = {AW{1'b1}};
   localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT - 1);
   localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

   rd_state_t       state_r, state_nxt_s;
   logic [AW-1:0]   rd_ptr_r;
   logic            rd_bank_r;
   logic [DCW-1:0]  drain_cnt_r;
   logic            load_s, issue_s, done_s;
   logic [RD_LAT-1:0] vld_sh_r, last_sh_r, bank_sh_r;

   // Next-state and per-cycle strobes of the read FSM.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      issue_s     = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (rd_start && frame_rdy) begin
               state_nxt_s = READ;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: begin
            issue_s = 1'b1;
            if (rd_ptr_r == PTR_LAST) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = READ;
            end
         end
         DRAIN: begin
            if (drain_cnt_r == DRAIN_LAST) begin
               done_s      = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Read pointer, owned bank and drain counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r    <= {AW{1'b0}};
         rd_bank_r   <= 1'b0;
         drain_cnt_r <= {DCW{1'b0}};
      end else begin
         if (load_s) begin
            rd_ptr_r  <= {AW{1'b0}};
            rd_bank_r <= next_bank;
         end else if (issue_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;   // wraps to 0 after the last address
         end
         if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
         end else begin
            drain_cnt_r <= {DCW{1'b0}};
         end
      end
   end

   // Delay line aligning valid/last/bank with the RAM read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_sh_r  <= {RD_LAT{1'b0}};
         last_sh_r <= {RD_LAT{1'b0}};
         bank_sh_r <= {RD_LAT{1'b0}};
      end else begin
         vld_sh_r[0]  <= issue_s;
         last_sh_r[0] <= issue_s && (rd_ptr_r == PTR_LAST);
         bank_sh_r[0] <= rd_bank_r;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sh_r[i]  <= vld_sh_r[i-1];
            last_sh_r[i] <= last_sh_r[i-1];
            bank_sh_r[i] <= bank_sh_r[i-1];
         end
      end
   end

   // RAM B enable: only the owned bank, only while addresses are issued.
   always_comb begin
      if (issue_s) begin
         ram_ceb = bank_sel(rd_bank_r);
      end else begin
         ram_ceb = 2'b00;
      end
   end

   assign ram_adb   = rd_ptr_r;
   assign busy      = (state_r != IDLE);
   assign rd_bank   = rd_bank_r;
   assign rd_done   = done_s;
   assign out_valid = vld_sh_r[RD_LAT-1];
   assign out_last  = last_sh_r[RD_LAT-1];
   assign out_bank  = bank_sh_r[RD_LAT-1];

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame buffer controller for two 512x16 SDPB sample RAMs.
// The mic PCM stream is written into one bank while the consumer bursts a
// complete frame out of the other. Write side and bank bookkeeping live here;
// the read burst is sequenced by pp_rd_seq.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid, in_data          input sample strobe / sample (no backpressure)
//   overflow                   sticky: a sample was dropped, both banks full
//   frame_rdy                  a full bank not currently being read exists
//   rd_start                   consumer request for one frame burst
//   out_valid/out_data/out_last  output sample stream
//   ram_cea, ram_ada, ram_din  RAM A write port (registered)
//   ram_ceb, ram_oce, ram_adb  RAM B read port
//   ram_dout0, ram_dout1       RAM read data of bank0 / bank1
module pingpong_frame_ctrl
   import acam_pkg::*;
#(
   parameter int AW     = FRAME_AW,
   parameter int DW     = SAMPLE_W,
   parameter int RD_LAT = 1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          overflow,
   output logic          frame_rdy,
   input  logic          rd_start,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [1:0]    ram_cea,
   output logic [AW-1:0] ram_ada,
   output logic [DW-1:0] ram_din,
   output logic [1:0]    ram_ceb,
   output logic          ram_oce,
   output logic [AW-1:0] ram_adb,
   input  logic [DW-1:0] ram_dout0,
   input  logic [DW-1:0] ram_dout1
);

   localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [1:0]    full_r, full_nxt_s, reading_mask_s;
   logic          wr_bank_r, order_r, overflow_r;
   logic [AW-1:0] wr_ptr_r, ada_r;
   logic [DW-1:0] din_r;
   logic [1:0]    cea_r;
   logic          wr_ok_s, wr_wrap_s;
   logic          busy_s, rd_bank_s, rd_done_s, out_bank_s, out_valid_s;

   // Banks fill strictly alternately and are drained in the same order, so
   // the oldest full bank is the one after the bank last released.
   pp_rd_seq #(.AW(AW), .RD_LAT(RD_LAT)) u_rd_seq (
      .clk       (clk),
      .reset     (reset),
      .rd_start  (rd_start),
      .frame_rdy (frame_rdy),
      .next_bank (order_r),
      .ram_ceb   (ram_ceb),
      .ram_adb   (ram_adb),
      .busy      (busy_s),
      .rd_bank   (rd_bank_s),
      .rd_done   (rd_done_s),
      .out_valid (out_valid_s),
      .out_last  (out_last),
      .out_bank  (out_bank_s)
   );

   assign wr_ok_s   = in_valid && !full_r[wr_bank_r];
   assign wr_wrap_s = wr_ok_s && (wr_ptr_r == PTR_LAST);

   // Bank owned by an active read burst is not offered as ready.
   always_comb begin
      if (busy_s) begin
         reading_mask_s = bank_sel(rd_bank_s);
      end else begin
         reading_mask_s = 2'b00;
      end
   end

   // Full flags: release at end of drain, set when the last sample is accepted.
   always_comb begin
      full_nxt_s = full_r;
      if (rd_done_s) begin
         full_nxt_s = full_nxt_s & ~bank_sel(rd_bank_s);
      end else begin
         full_nxt_s = full_nxt_s;
      end
      if (wr_wrap_s) begin
         full_nxt_s = full_nxt_s | bank_sel(wr_bank_r);
      end else begin
         full_nxt_s = full_nxt_s;
      end
   end

   // Write port, write pointer, bank bookkeeping and overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r     <= 2'b00;
         wr_bank_r  <= 1'b0;
         wr_ptr_r   <= {AW{1'b0}};
         order_r    <= 1'b0;
         overflow_r <= 1'b0;
         cea_r      <= 2'b00;
         ada_r      <= {AW{1'b0}};
         din_r      <= {DW{1'b0}};
      end else begin
         full_r <= full_nxt_s;
         if (wr_ok_s) begin
            cea_r <= bank_sel(wr_bank_r);
            ada_r <= wr_ptr_r;
            din_r <= in_data;
         end else begin
            cea_r <= 2'b00;
         end
         if (wr_wrap_s) begin
            wr_ptr_r  <= {AW{1'b0}};
            wr_bank_r <= ~wr_bank_r;
         end else if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         // A blocked bank drops the sample; the pointer stays put.
         if (in_valid && full_r[wr_bank_r]) begin
            overflow_r <= 1'b1;
         end
         if (rd_done_s) begin
            order_r <= ~rd_bank_s;
         end
      end
   end

   // Output data follows the bank that was addressed RD_LAT cycles ago.
   always_comb begin
      if (out_valid_s) begin
         out_data = out_bank_s ? ram_dout1 : ram_dout0;
      end else begin
         out_data = {DW{1'b0}};
      end
   end

   assign frame_rdy = |(full_r & ~reading_mask_s);
   assign out_valid = out_valid_s;
   assign overflow  = overflow_r;
   assign ram_cea   = cea_r;
   assign ram_ada   = ada_r;
   assign ram_din   = din_r;
   assign ram_oce   = 1'b1;

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Self-checking bench for pingpong_frame_ctrl with two modelled SDPB banks
// (1-cycle read latency). Expected frames are queued by the stimulus side and
// compared by an independent output monitor.
`timescale 1ns/1ps
module tb_pingpong_frame_ctrl;

   logic        clk, reset, in_valid, rd_start;
   logic [15:0] in_data, out_data, ram_din, ram_dout0, ram_dout1;
   logic        overflow, frame_rdy, out_valid, out_last, ram_oce;
   logic [1:0]  ram_cea, ram_ceb;
   logic [8:0]  ram_ada, ram_adb;

   pingpong_frame_ctrl dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .overflow(overflow), .frame_rdy(frame_rdy), .rd_start(rd_start),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
      .ram_ceb(ram_ceb), .ram_oce(ram_oce), .ram_adb(ram_adb),
      .ram_dout0(ram_dout0), .ram_dout1(ram_dout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SDPB bank models
   logic [15:0] mem0 [512];
   logic [15:0] mem1 [512];
   initial begin
      ram_dout0 = 16'h0000;
      ram_dout1 = 16'h0000;
   end
   always @(posedge clk) begin
      if (ram_cea[0]) mem0[ram_ada] <= ram_din;
      if (ram_cea[1]) mem1[ram_ada] <= ram_din;
      if (ram_ceb[0]) ram_dout0 <= mem0[ram_adb];
      if (ram_ceb[1]) ram_dout1 <= mem1[ram_adb];
   end

   int nchk = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model of the write side
   logic [15:0] mmem [2][512];
   bit   [1:0]  mfull;
   int          mwb, mwp;
   bit          mover;

   task automatic model_reset();
      mfull = 2'b00; mwb = 0; mwp = 0; mover = 1'b0;
   endtask

   // Scoreboard
   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic [8:0]  idx;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int   nout = 0;
   int   last_cnt = 0;
   logic prev_valid = 1'b0;

   // Output monitor: every valid output must match the head of the queue.
   always @(negedge clk) begin
      if (out_valid) begin
         nout++;
         if (sb.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_out: actual data=%0h required no output at %0t", out_data, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("out_data", {16'h0000, out_data}, {16'h0000, mon_e.data});
            chk("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
            if (mon_e.idx != 9'd0) chk("out_gap", {31'd0, prev_valid}, 32'd1);
            if (mon_e.last) last_cnt++;
         end
      end
      prev_valid = out_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; in_valid = 1'b0; rd_start = 1'b0; in_data = 16'h0000;
      repeat (2) tick();
      reset = 1'b0;
      model_reset();
      sb.delete();
   endtask

   task automatic write_sample(input logic [15:0] d, input int gap);
      in_valid = 1'b1;
      in_data  = d;
      if (!mfull[mwb]) begin
         mmem[mwb][mwp] = d;
         if (mwp == 511) begin
            mfull[mwb] = 1'b1;
            mwp = 0;
            mwb ^= 1;
         end else begin
            mwp++;
         end
      end else begin
         mover = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic do_read(input int bank, input bit extra);
      exp_t e;
      int   lc0;
      bit   done;
      for (int i = 0; i < 512; i++) begin
         e.data = mmem[bank][i];
         e.last = (i == 511);
         e.idx  = 9'(i);
         sb.push_back(e);
      end
      lc0 = last_cnt;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("rd_bank_sel", {30'd0, ram_ceb}, (bank == 1) ? 32'd2 : 32'd1);
      if (extra) begin
         repeat (10) tick();
         rd_start = 1'b1;
         tick();
         rd_start = 1'b0;
         chk("rd_ptr_busy_start", {23'd0, ram_adb}, 32'd11);
         chk("rd_bank_busy_start", {30'd0, ram_ceb}, (bank == 1) ? 32'd2 : 32'd1);
      end
      done = 1'b0;
      for (int c = 0; c < 1200 && !done; c++) begin
         tick();
         if (last_cnt != lc0) done = 1'b1;
      end
      chk("rd_done", {31'd0, done}, 32'd1);
      mfull[bank] = 1'b0;
      chk("sb_empty", sb.size(), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n0;
      bit  hit;
      apply_reset();

      // Reset state
      chk("rst_valid_last", {30'd0, out_valid, out_last}, 32'd0);
      chk("rst_ovf_rdy", {30'd0, overflow, frame_rdy}, 32'd0);
      chk("rst_ce", {28'd0, ram_cea, ram_ceb}, 32'd0);
      chk("rst_oce", {31'd0, ram_oce}, 32'd1);
      chk("rst_addr_data", {7'd0, ram_ada, ram_din}, 32'd0);
      chk("rst_out_data", {16'h0000, out_data}, 32'd0);

      // rd_start without any full bank is ignored
      n0 = nout;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      repeat (5) tick();
      chk("idle_start_no_out", nout - n0, 32'd0);
      chk("idle_start_ceb", {30'd0, ram_ceb}, 32'd0);
      chk("idle_start_adb", {23'd0, ram_adb}, 32'd0);

      // Test 1: one frame 0..511 then stream it
      write_sample(16'd0, 0);
      chk("first_write_cea", {30'd0, ram_cea}, 32'd1);
      chk("first_write_ada", {23'd0, ram_ada}, 32'd0);
      for (int i = 1; i < 511; i++) write_sample(16'(i), 0);
      chk("rdy_before_last", {31'd0, frame_rdy}, 32'd0);
      write_sample(16'd511, 0);
      chk("rdy_after_last", {31'd0, frame_rdy}, 32'd1);
      do_read(0, 1'b0);
      chk("rdy_after_read1", {31'd0, frame_rdy}, 32'd0);

      // Tests 2/4/5: fill both banks, overflow, ordered reads, busy rd_start
      apply_reset();
      for (int i = 0; i < 1024; i++) write_sample(16'(16'h1000 + i), 0);
      chk("both_full_rdy", {31'd0, frame_rdy}, 32'd1);
      chk("no_ovf_at_1024", {31'd0, overflow}, 32'd0);
      write_sample(16'hBEEF, 0);
      chk("drop_no_cea", {30'd0, ram_cea}, 32'd0);
      chk("ovf_set", {31'd0, overflow}, {31'd0, mover});
      repeat (5) tick();
      chk("ovf_held", {31'd0, overflow}, 32'd1);
      do_read(0, 1'b1);
      chk("rdy_bank1_left", {31'd0, frame_rdy}, 32'd1);
      do_read(1, 1'b0);
      chk("rdy_all_read", {31'd0, frame_rdy}, 32'd0);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Test 6: reset in the middle of a burst
      for (int i = 0; i < 512; i++) write_sample(16'(16'h3000 + i), 0);
      for (int i = 0; i < 512; i++) begin
         exp_t e;
         e.data = mmem[0][i];
         e.last = (i == 511);
         e.idx  = 9'(i);
         sb.push_back(e);
      end
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 700 && !hit; c++) begin
         @(negedge clk);
         if (out_valid && out_data == 16'h30C8) hit = 1'b1;
      end
      chk("reset_point_reached", {31'd0, hit}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      sb.delete();
      @(negedge clk);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_rdy_ovf", {30'd0, frame_rdy, overflow}, 32'd0);
      chk("midrst_ceb", {30'd0, ram_ceb}, 32'd0);
      tick();
      write_sample(16'h7000, 0);
      chk("midrst_wrptr", {23'd0, ram_ada}, 32'd0);
      chk("midrst_wrbank", {30'd0, ram_cea}, 32'd1);

      // Test 3: slow continuous input with back-to-back reads
      fork
         begin
            for (int i = 1; i < 1536; i++) write_sample(16'(16'h5000 + i), 3);
         end
         begin
            for (int k = 0; k < 3; k++) begin
               bit rdy;
               rdy = 1'b0;
               for (int c = 0; c < 3000 && !rdy; c++) begin
                  tick();
                  if (frame_rdy) rdy = 1'b1;
               end
               chk("stream_frame_rdy", {31'd0, rdy}, 32'd1);
               do_read(k % 2, 1'b0);
            end
         end
      join
      repeat (4) tick();
      chk("stream_no_ovf", {31'd0, overflow}, {31'd0, mover});
      chk("stream_all_read", {31'd0, frame_rdy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
